imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the 16-bit multicycle processor. It receives a framed byte stream over a valid/ready handshake, assembles 16-bit big-endian words and writes them into instruction memory from address 0 upward. It verifies an XOR checksum and holds the processor in reset until a load completes cleanly. It is the write-side counterpart of the datapath's instruction fetch: the datapath only reads instruction memory, and this block is the only writer.

## Interface
- IM_DEPTH, 256: instruction-memory capacity in 16-bit words; the largest legal word count.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a load when sampled high in IDLE, DONE or ERR; ignored in every other state.
- in_valid  in  1  byte-stream source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; a byte transfers on a rising edge where in_valid && in_ready.
- im_wr_en  out  1  one-cycle instruction-memory write strobe.
- im_wr_addr  out  16  word address for the write.
- im_wr_data  out  16  word to write.
- cpu_hold  out  1  high keeps the processor datapath in reset.
- done  out  1  last load completed with a good checksum.
- error  out  1  last load failed (length overflow or checksum mismatch).

## Operation
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then N words as hi byte then lo byte, then CHK. CHK is the 8-bit XOR of every byte from LEN_HI through the last data byte.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
- in_ready is a Moore decode: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 otherwise.
- IDLE/DONE/ERR with start=1: go to LEN_HI. On entry, clear the word index, the running XOR, done and error, and set cpu_hold=1.
- LEN_HI on accept: latch len[15:8], fold the byte into the XOR, go to LEN_LO.
- LEN_LO on accept: latch len[7:0] and fold into the XOR. Then:
  - if {len_hi, byte} > IM_DEPTH, go to ERR;
  - else if it is 0, go to CHECK;
  - else go to DATA_HI.
- DATA_HI on accept: hold the byte, fold it into the XOR, go to DATA_LO.
- DATA_LO on accept, on the same edge:
  - load im_wr_data={hi,lo}, load im_wr_addr=index, and set im_wr_en=1 for exactly the following cycle;
  - fold the byte into the XOR and increment index;
  - go to CHECK if index+1==N, else DATA_HI.
- CHECK on accept: go to DONE if byte==XOR, else ERR.
- DONE: done=1, cpu_hold=0. ERR: error=1, cpu_hold=1. Both hold until start.
- The index is 16 bits. It cannot wrap because N ≤ IM_DEPTH is enforced before any write.
- No bytes are accepted in IDLE, DONE or ERR. Source bytes presented there remain pending.
- Words already written before an ERR stay in memory. The loader never erases.

## Timing
- Reset (asynchronous, immediate) sets:
  - state=IDLE, in_ready=0, im_wr_en=0, im_wr_addr=0, im_wr_data=0;
  - cpu_hold=1, done=0, error=0;
  - len, index and XOR = 0.
- A reset mid-load aborts immediately. The processor stays held. A new start is required.
- Throughput is one byte per cycle with in_valid held high, so at most one word write every 2 cycles.
- A start edge in IDLE makes in_ready=1 on the following cycle.
- im_wr_en is high the cycle after the lo-byte accept edge. Address and data are stable for that whole cycle.
- The CHK accept edge is followed by done/error valid and cpu_hold updated in the next cycle, with no extra latency.
- start while in_ready=1 has no effect.
- in_valid gaps of any length simply stall the FSM; no timeout.

## Test plan
- Reset: assert rst=0 mid-cycle -> all outputs at reset values with no clock edge; cpu_hold=1, in_ready=0.
- Good load: start, then bytes 00 03 12 34 AB CD 00 01 42 at full rate -> writes [0]=1234, [1]=ABCD, [2]=0001, one strobe each, 2 cycles apart; done=1 and cpu_hold=0 one cycle after 42 is accepted.
- Bad checksum: same frame with CHK=43 -> same three writes; error=1, done=0, cpu_hold=1; start then returns to LEN_HI and clears error.
- Overflow: start, bytes 01 01 (N=257, IM_DEPTH=256) -> ERR after the second byte; no im_wr_en; in_ready=0.
- Zero length and stalls: start, bytes 00 00 00 with in_valid low 3 cycles between bytes -> no writes; done=1; in_ready stays high through the gaps.
- Reset mid-load: assert rst after the hi byte of word 1 of the good frame -> word 0 written, no further strobes; after release, start and a full good frame -> done=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream to instruction-memory writer with XOR checksum;
// holds the processor in reset until a load completes with a good checksum.
module imem_loader #(
    parameter int IM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_wr_en,
    output logic [15:0] im_wr_addr,
    output logic [15:0] im_wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR} state_t;

    localparam logic [15:0] DEPTH = 16'(IM_DEPTH);

    state_t      state, state_nx;
    logic [15:0] len, idx;
    logic [7:0]  xsum, hi_byte;
    logic        acc, launch;
    logic [15:0] len_nx, idx_nx;

    assign in_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
    assign acc      = in_valid && in_ready;
    assign launch   = start && (state inside {IDLE, DONE, ERR});
    assign len_nx   = {len[15:8], in_data};
    assign idx_nx   = idx + 16'd1;
    assign done     = state == DONE;
    assign error    = state == ERR;
    assign cpu_hold = state != DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: state_nx = launch ? LEN_HI : state;
            LEN_HI:  state_nx = acc ? LEN_LO : state;
            LEN_LO:  state_nx = !acc ? state : (len_nx > DEPTH) ? ERR : (len_nx == 16'd0) ? CHECK : DATA_HI;
            DATA_HI: state_nx = acc ? DATA_LO : state;
            DATA_LO: state_nx = !acc ? state : (idx_nx == len) ? CHECK : DATA_HI;
            CHECK:   state_nx = !acc ? state : (in_data == xsum) ? DONE : ERR;
            default: state_nx = IDLE;
        endcase
    end

    // The write strobe is a registered one-cycle pulse; address/data stay put until the next word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len        <= '0;
            idx        <= '0;
            xsum       <= '0;
            hi_byte    <= '0;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
        end else begin
            im_wr_en <= 1'b0;
            if (launch) begin
                idx  <= '0;
                xsum <= '0;
            end
            if (acc && state != CHECK) xsum <= xsum ^ in_data;
            if (acc && state == LEN_HI) len[15:8] <= in_data;
            if (acc && state == LEN_LO) len[7:0] <= in_data;
            if (acc && state == DATA_HI) hi_byte <= in_data;
            if (acc && state == DATA_LO) begin
                im_wr_en   <= 1'b1;
                im_wr_addr <= idx;
                im_wr_data <= {hi_byte, in_data};
                idx        <= idx_nx;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, im_wr_en, cpu_hold, done, error;
    logic [15:0] im_wr_addr, im_wr_data;
    int          checks = 0;
    int          errors = 0;
    int          strobes = 0;
    int          base;

    imem_loader #(.IM_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
        .im_wr_data(im_wr_data), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (im_wr_en === 1'b1) strobes++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_ready", 16'(in_ready), 16'd1);
    endtask

    task automatic words(input logic [7:0] n);
        logic [15:0] w [3];
        w[0] = 16'h1234;
        w[1] = 16'hABCD;
        w[2] = 16'h0001;
        for (int i = 0; i < int'(n); i++) begin
            step(w[i][15:8]);
            chk("hi_no_strobe", 16'(im_wr_en), 16'd0);
            step(w[i][7:0]);
            chk("strobe", 16'(im_wr_en), 16'd1);
            chk("wr_addr", im_wr_addr, 16'(i));
            chk("wr_data", im_wr_data, w[i]);
        end
    endtask

    task automatic good_frame(input logic [7:0] c);
        step(8'h00);
        step(8'h03);
        words(8'd3);
        step(c);
        chk("chk_no_strobe", 16'(im_wr_en), 16'd0);
        chk("chk_ready", 16'(in_ready), 16'd0);
    endtask

    initial begin
        #12 rst = 1'b0;
        #1;
        chk("rst_ready", 16'(in_ready), 16'd0);
        chk("rst_wr_en", 16'(im_wr_en), 16'd0);
        chk("rst_addr", im_wr_addr, 16'h0000);
        chk("rst_data", im_wr_data, 16'h0000);
        chk("rst_hold", 16'(cpu_hold), 16'd1);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_error", 16'(error), 16'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle_cycle();
        chk("idle_ready", 16'(in_ready), 16'd0);

        base = strobes;
        go();
        chk("load_hold", 16'(cpu_hold), 16'd1);
        good_frame(8'h42);
        chk("good_done", 16'(done), 16'd1);
        chk("good_error", 16'(error), 16'd0);
        chk("good_hold", 16'(cpu_hold), 16'd0);
        chk("good_strobes", 16'(strobes - base), 16'd3);
        in_valid = 1'b1;
        in_data  = 8'h55;
        idle_cycle();
        chk("done_pending", 16'(in_ready), 16'd0);
        chk("done_holds", 16'(done), 16'd1);
        in_valid = 1'b0;

        base = strobes;
        go();
        chk("restart_done_clr", 16'(done), 16'd0);
        good_frame(8'h43);
        chk("bad_error", 16'(error), 16'd1);
        chk("bad_done", 16'(done), 16'd0);
        chk("bad_hold", 16'(cpu_hold), 16'd1);
        chk("bad_strobes", 16'(strobes - base), 16'd3);
        go();
        chk("restart_err_clr", 16'(error), 16'd0);

        base = strobes;
        step(8'h01);
        chk("ovf_mid_error", 16'(error), 16'd0);
        step(8'h01);
        chk("ovf_error", 16'(error), 16'd1);
        chk("ovf_ready", 16'(in_ready), 16'd0);
        chk("ovf_hold", 16'(cpu_hold), 16'd1);
        idle_cycle();
        chk("ovf_strobes", 16'(strobes - base), 16'd0);

        base = strobes;
        go();
        for (int b = 0; b < 3; b++) begin
            step(8'h00);
            if (b < 2) begin
                for (int g = 0; g < 3; g++) begin
                    start = (g == 1);
                    idle_cycle();
                    chk("gap_ready", 16'(in_ready), 16'd1);
                end
                start = 1'b0;
            end
        end
        chk("zero_done", 16'(done), 16'd1);
        chk("zero_error", 16'(error), 16'd0);
        chk("zero_strobes", 16'(strobes - base), 16'd0);

        base = strobes;
        go();
        step(8'h00);
        step(8'h03);
        words(8'd1);
        step(8'hAB);
        #2 rst = 1'b0;
        #1;
        chk("abort_ready", 16'(in_ready), 16'd0);
        chk("abort_hold", 16'(cpu_hold), 16'd1);
        chk("abort_wr_en", 16'(im_wr_en), 16'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hCD;
        idle_cycle();
        idle_cycle();
        in_valid = 1'b0;
        chk("abort_idle_ready", 16'(in_ready), 16'd0);
        chk("abort_strobes", 16'(strobes - base), 16'd1);
        chk("abort_done", 16'(done), 16'd0);
        go();
        good_frame(8'h42);
        chk("reload_done", 16'(done), 16'd1);
        chk("reload_hold", 16'(cpu_hold), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
